// File: rtl/banked_pmem_pkg.sv
// Shared types and defaults for the banked physical-memory model.
package pmem_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  localparam int PMEM_DEF_NUM_CH     = 2;
  localparam int PMEM_DEF_DEPTH      = 512;
  localparam int PMEM_DEF_LINE_BITS  = 256;
  localparam int PMEM_DEF_ADDR_WIDTH = 16;
  localparam int PMEM_DEF_LATENCY    = 4;

  // Byte-offset bits inside one line; these address bits never reach the index.
  function automatic int PMEM_OFFSET_BITS(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/banked_pmem_rr_arbiter.sv
// Round-robin arbiter: first requester found searching ptr, ptr+1, ... mod NUM_CH.
module pmem_rr_arbiter
  import pmem_types::*;
#(
  parameter int NUM_CH = PMEM_DEF_NUM_CH,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gidx
);

  // Scan from the farthest slot back to ptr so the slot closest to ptr wins.
  always_comb begin
    int c;
    gnt  = '0;
    gidx = '0;
    c    = 0;
    if (en) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        c = int'(ptr) + i;
        if (c >= NUM_CH) c = c - NUM_CH;
        if (req[c]) begin
          gnt    = '0;
          gnt[c] = 1'b1;
          gidx   = CH_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/banked_pmem.sv
// Multi-channel line-wide physical memory with round-robin arbitration and
// fixed access latency. Optional macro BANKED_PMEM_ADDR_CHECK_EN flags
// out-of-range line indices instead of wrapping them.
module banked_pmem
  import pmem_types::*;
#(
  parameter int NUM_CH     = PMEM_DEF_NUM_CH,
  parameter int DEPTH      = PMEM_DEF_DEPTH,
  parameter int LINE_BITS  = PMEM_DEF_LINE_BITS,
  parameter int ADDR_WIDTH = PMEM_DEF_ADDR_WIDTH,
  parameter int LATENCY    = PMEM_DEF_LATENCY
)(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CH-1:0]                    read,
  input  logic [NUM_CH-1:0]                    write,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    address,
  input  logic [NUM_CH-1:0][LINE_BITS-1:0]     wdata,
  output logic [NUM_CH-1:0]                    resp,
  output logic [LINE_BITS-1:0]                 rdata,
  output logic [NUM_CH-1:0]                    err
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W  = PMEM_OFFSET_BITS(LINE_BITS);
  localparam int LIDX_W = ADDR_WIDTH - OFF_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 8;

  // Request latched at the grant edge; later input changes are invisible.
  typedef struct packed {
    logic                 wr;
    logic                 bad;
    logic [IDX_W-1:0]     idx;
    logic [LINE_BITS-1:0] data;
  } req_t;

  logic [LINE_BITS-1:0] mem [DEPTH];

  pmem_state_t       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CH_W-1:0]   ptr, gidx;
  logic [NUM_CH-1:0] gnt, gnt_q;
  req_t              cur;
  logic              ld, acc;
  logic [LIDX_W-1:0] g_lidx;
  logic              g_bad;

  pmem_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req  (read | write),
    .ptr  (ptr),
    .en   (state == IDLE),
    .gnt  (gnt),
    .gidx (gidx)
  );

  assign g_lidx = address[gidx][ADDR_WIDTH-1:OFF_W];

`ifdef BANKED_PMEM_ADDR_CHECK_EN
  assign g_bad = (32'(g_lidx) >= 32'(DEPTH));
  assign err   = (state == RESP && cur.bad) ? gnt_q : '0;
`else
  assign g_bad = 1'b0;
  assign err   = '0;
`endif

  assign resp = (state == RESP) ? gnt_q : '0;

  // Next-state: LATENCY=1 still spends one BUSY cycle (cnt already 0) so the
  // response lands LATENCY cycles after the grant edge for every setting.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ld      = 1'b0;
    acc     = 1'b0;
    case (state)
      IDLE: if (|gnt) begin
        ld      = 1'b1;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = BUSY;
      end
      BUSY: if (cnt == '0) begin
        acc     = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d   = cnt - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, latched request and read-data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt_q <= '0;
      cur   <= '0;
      rdata <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (ld) begin
        gnt_q <= gnt;
        ptr   <= (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
        cur   <= '{wr: write[gidx], bad: g_bad, idx: g_lidx[IDX_W-1:0], data: wdata[gidx]};
      end
      if (acc && !cur.wr) rdata <= cur.bad ? '0 : mem[cur.idx];
    end
  end

  // Storage has no reset so its contents survive reset_n; a write cut off by
  // reset never reaches acc and is dropped.
  always_ff @(posedge clk) begin
    if (acc && cur.wr && !cur.bad) mem[cur.idx] <= cur.data;
  end

endmodule

// File: tb/tb_banked_pmem.sv
// Bench for banked_pmem: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model.
module tb_banked_pmem;

  localparam int NCH = 2, DEP = 512, LB = 256, AW = 16, LAT = 4;
  localparam int LBYTES = LB / 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [NCH-1:0] read, write, resp, err;
  logic [NCH-1:0][AW-1:0] address;
  logic [NCH-1:0][LB-1:0] wdata;
  logic [LB-1:0] rdata;

  logic [NCH-1:0] read1, write1, resp1, err1;
  logic [NCH-1:0][AW-1:0] address1;
  logic [NCH-1:0][LB-1:0] wdata1;
  logic [LB-1:0] rdata1;

  banked_pmem #(.NUM_CH(NCH), .DEPTH(DEP), .LINE_BITS(LB), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
    .wdata(wdata), .resp(resp), .rdata(rdata), .err(err));

  banked_pmem #(.NUM_CH(NCH), .DEPTH(DEP), .LINE_BITS(LB), .ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .read(read1), .write(write1), .address(address1),
    .wdata(wdata1), .resp(resp1), .rdata(rdata1), .err(err1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit rnd_en = 0;

  // requester side
  bit d_act [NCH], d_rd [NCH], d_wr [NCH];
  logic [AW-1:0] d_addr [NCH];
  logic [LB-1:0] d_data [NCH];

  // model
  logic [LB-1:0] mmem [int];
  bit m_pend, m_wr, m_bad;
  int m_g, m_done, m_idx, m_ptr, m_free;
  logic [LB-1:0] m_data;

  // observations of the DUT
  int last_resp_cyc [NCH];
  int resp_cnt = 0;
  logic [LB-1:0] last_rdata;
  logic [NCH-1:0] last_err;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
  endtask

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] v;
    for (int w = 0; w < LB / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ptr = 0; m_free = 0;
  endtask

  // Decide what the edge just taken granted, from the inputs held across it.
  task automatic model_edge();
    bit found;
    int line;
    if (!reset_n) begin model_reset(); return; end
    found = 0;
    if (!m_pend && cyc >= m_free) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (!found && (read[c] || write[c])) begin
          found  = 1;
          m_pend = 1; m_g = c;
          m_done = cyc + LAT; m_free = cyc + LAT + 2;
          m_ptr  = (c + 1) % NCH;
          m_wr   = write[c];
          m_data = wdata[c];
          line   = int'(address[c]) / LBYTES;
`ifdef BANKED_PMEM_ADDR_CHECK_EN
          m_bad = (line >= DEP); m_idx = line;
`else
          m_bad = 0; m_idx = line % DEP;
`endif
        end
      end
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      if (rnd_en && !d_act[c] && $urandom_range(0, 2) == 0) begin
        int k, line;
        k    = $urandom_range(0, 2);
        line = ($urandom_range(0, 9) == 0) ? 512 + $urandom_range(0, 7) : $urandom_range(0, 15);
        d_act[c] = 1; d_rd[c] = (k != 1); d_wr[c] = (k != 0);
        d_addr[c] = AW'(line * LBYTES + $urandom_range(0, LBYTES - 1));
        d_data[c] = rnd_line();
      end
      read[c]    = d_act[c] & d_rd[c];
      write[c]   = d_act[c] & d_wr[c];
      address[c] = d_addr[c];
      wdata[c]   = d_data[c];
      // granted request: its inputs may wander, the DUT must ignore that
      if (rnd_en && m_pend && m_g == c && $urandom_range(0, 3) == 0) begin
        address[c] = AW'($urandom);
        wdata[c]   = rnd_line();
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] er, ee;
    logic [LB-1:0] ed;
    bit dchk;
    er = '0; ee = '0; ed = '0; dchk = 0;
    if (|resp) begin
      resp_cnt++;
      last_rdata = rdata; last_err = err;
      for (int c = 0; c < NCH; c++) if (resp[c]) last_resp_cyc[c] = cyc;
    end
    if (m_pend && cyc == m_done) begin
      er[m_g] = 1'b1; ee[m_g] = m_bad;
      if (m_wr) begin
        if (!m_bad) mmem[m_idx] = m_data;
      end else if (m_bad) begin
        ed = '0; dchk = 1;
      end else if (mmem.exists(m_idx)) begin
        ed = mmem[m_idx]; dchk = 1;
      end
      m_pend = 0; d_act[m_g] = 0;
    end
    chk("resp", LB'(resp), LB'(er));
    chk("err", LB'(err), LB'(ee));
    if (dchk) chk("rdata", rdata, ed);
  endtask

  task automatic cycle_step();
    @(posedge clk); cyc++; #1;
    model_edge();
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic set_op(input int c, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [LB-1:0] d);
    d_act[c] = 1; d_rd[c] = rd; d_wr[c] = wr; d_addr[c] = a; d_data[c] = d;
  endtask

  task automatic wait_done(input int c, input string nm);
    int n = 0;
    while (d_act[c] && n < 100) begin cycle_step(); n++; end
    if (d_act[c]) begin n_chk++; $display("FAIL %s: timeout waiting for resp, got none want resp", nm); end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    for (int c = 0; c < NCH; c++) d_act[c] = 0;
    read = '0; write = '0;
    repeat (n) cycle_step();
    reset_n = 1'b1;
  endtask

  initial begin
    int rq, base, pat;
    read = '0; write = '0; address = '0; wdata = '0;
    read1 = '0; write1 = '0; address1 = '0; wdata1 = '0;
    for (int c = 0; c < NCH; c++) begin
      d_act[c] = 0; d_rd[c] = 0; d_wr[c] = 0; d_addr[c] = '0; d_data[c] = '0; last_resp_cyc[c] = -1;
    end
    model_reset();

    do_reset(3);
    chk("reset_rdata", rdata, '0);
    chk("reset_resp", LB'(resp), '0);
    chk("reset_err", LB'(err), '0);

    // write then read on ch0, line 2
    rq = cyc + 1;
    set_op(0, 0, 1, 16'h0040, {32{8'hA5}});
    wait_done(0, "wr_a5");
    chk("wr_latency", LB'(last_resp_cyc[0] - rq), LB'(5));
    base = last_resp_cyc[0];
    rq = cyc + 1;
    set_op(0, 1, 0, 16'h0040, '0);
    wait_done(0, "rd_a5");
    chk("rd_latency", LB'(last_resp_cyc[0] - rq), LB'(5));
    chk("grant_gap", LB'(last_resp_cyc[0] - base), LB'(6));
    chk("rd_a5_data", last_rdata, {32{8'hA5}});

    // contention from a fresh pointer
    do_reset(2);
    rq = cyc + 1;
    set_op(0, 1, 0, 16'h0040, '0);
    set_op(1, 1, 0, 16'h0040, '0);
    wait_done(0, "cont_ch0");
    chk("cont_ch0_first", LB'(last_resp_cyc[0] - rq), LB'(5));
    set_op(0, 1, 0, 16'h0044, '0);
    wait_done(1, "cont_ch1");
    wait_done(0, "cont_ch0b");
    chk("cont_ch1_second", LB'(last_resp_cyc[1] - rq), LB'(11));
    chk("cont_ch0_third", LB'(last_resp_cyc[0] - rq), LB'(17));

    // read+write on one channel acts as a write
    set_op(1, 1, 1, 16'h00A0, {16{16'h1234}});
    wait_done(1, "rw_both");
    set_op(1, 1, 0, 16'h00A0, '0);
    wait_done(1, "rw_read");
    chk("rw_collision", last_rdata, {16{16'h1234}});

    // reset in the middle of a write to line 3
    set_op(0, 0, 1, 16'h0060, {LB{1'b1}});
    wait_done(0, "line3_ff");
    set_op(0, 0, 1, 16'h0060, {32{8'h3C}});
    repeat (3) cycle_step();
    pat = resp_cnt;
    do_reset(2);
    repeat (6) cycle_step();
    chk("midreset_no_resp", LB'(resp_cnt - pat), '0);
    set_op(0, 1, 0, 16'h0060, '0);
    wait_done(0, "line3_rd");
    chk("midreset_retained", last_rdata, {LB{1'b1}});

    // out-of-range index
    set_op(0, 0, 1, 16'h0000, {32{8'h0F}});
    wait_done(0, "line0_wr");
    set_op(0, 1, 0, 16'h4000, '0);
    wait_done(0, "oor_rd");
`ifdef BANKED_PMEM_ADDR_CHECK_EN
    chk("oor_err", LB'(last_err), LB'(2'b01));
    chk("oor_rdata", last_rdata, '0);
`else
    chk("oor_err", LB'(last_err), LB'(2'b00));
    chk("oor_rdata", last_rdata, {32{8'h0F}});
`endif

    // randomized traffic
    rnd_en = 1;
    repeat (1500) cycle_step();
    rnd_en = 0;
    for (int c = 0; c < NCH; c++) wait_done(c, "drain");

    // LATENCY=1 instance: ch0 held continuously, grants every 3 cycles
    begin
      logic [9:0] seen;
      seen = '0;
      read1[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
        cycle_step();
        seen[k] = resp1[0];
        if (resp1[1] || err1 != '0) chk("lat1_stray", LB'({err1, resp1}), LB'({2'b00, resp1[0], 1'b0}));
      end
      read1[0] = 1'b0;
      chk("lat1_pattern", LB'(seen), LB'(10'h092));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
